// File: rtl/cube_pkg.sv
// Shared scan-state encoding and sizing helper for the LED cube frame scanner.
package cube_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BLANK = 3'd1,
    FETCH = 3'd2,
    LATCH = 3'd3,
    DRIVE = 3'd4
  } scan_state_e;

  // $clog2 that never returns 0, so single-entry dimensions still get a 1-bit field.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/cube_pwm_timer.sv
// One DRIVE period of (2**BRIGHT_W-1)*STEP_CYC cycles; on_o is high for the first duty*STEP_CYC cycles.
module cube_pwm_timer
  import cube_pkg::*;
#(
  parameter int unsigned BRIGHT_W = 4,
  parameter int unsigned STEP_CYC = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [BRIGHT_W-1:0] duty_i,
  output logic                on_o,
  output logic                done_o
);

  localparam int unsigned PERIOD = ((32'd1 << BRIGHT_W) - 32'd1) * STEP_CYC;
  localparam int unsigned CNT_W  = clog2_min1((32'd1 << BRIGHT_W) * STEP_CYC);

  logic             active_q;
  logic             on_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] thr_q;
  logic [CNT_W-1:0] thr_d;
  logic [CNT_W-1:0] cnt_inc;

  assign thr_d   = CNT_W'(duty_i) * CNT_W'(STEP_CYC);
  assign cnt_inc = cnt_q + CNT_W'(1);

  // start_i arrives the cycle before the period, so on/done line up with the DRIVE cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      on_q     <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      thr_q    <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      thr_q    <= thr_d;
      on_q     <= (thr_d != '0);
      done_q   <= (PERIOD == 32'd1);
    end else if (active_q) begin
      if (done_q) begin
        active_q <= 1'b0;
        on_q     <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        cnt_q  <= cnt_inc;
        on_q   <= (cnt_inc < thr_q);
        done_q <= (cnt_inc == CNT_W'(PERIOD - 32'd1));
      end
    end
  end

  assign on_o   = on_q;
  assign done_o = done_q;

endmodule

// File: rtl/led_cube_frame_scanner.sv
// Frame scanner: per layer blank, fetch and latch every column word, then PWM-drive that layer.
module led_cube_frame_scanner
  import cube_pkg::*;
#(
  parameter int unsigned LAYERS    = 8,
  parameter int unsigned COLS      = 8,
  parameter int unsigned ROW_W     = 8,
  parameter int unsigned BRIGHT_W  = 4,
  parameter int unsigned STEP_CYC  = 64,
  parameter int unsigned LATCH_CYC = 2,
  parameter int unsigned BLANK_CYC = 2
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic                                               start,
  input  logic                                               stop,
  input  logic                                               oneshot,
  input  logic [BRIGHT_W-1:0]                                brightness,
  output logic [clog2_min1(LAYERS)+clog2_min1(COLS)-1:0]     rd_addr,
  input  logic [ROW_W-1:0]                                   rd_data,
  output logic [ROW_W-1:0]                                   data,
  output logic [COLS-1:0]                                    latches,
  output logic [LAYERS-1:0]                                  layers,
  output logic                                               busy,
  output logic                                               frame_done,
  output logic [clog2_min1(LAYERS)-1:0]                      layer_idx
);

  localparam int unsigned LAYER_AW = clog2_min1(LAYERS);
  localparam int unsigned COL_AW   = clog2_min1(COLS);
  localparam int unsigned CNT_W    = clog2_min1((BLANK_CYC > LATCH_CYC) ? BLANK_CYC : LATCH_CYC);
  localparam logic [LAYER_AW-1:0] LAYER_TOP = LAYER_AW'(LAYERS - 32'd1);
  localparam logic [COL_AW-1:0]   COL_TOP   = COL_AW'(COLS - 32'd1);

  scan_state_e                 state_q;
  logic [CNT_W-1:0]            cnt_q;
  logic [COL_AW-1:0]           col_q;
  logic [LAYER_AW-1:0]         layer_q;
  logic [LAYER_AW-1:0]         layer_nxt;
  logic                        oneshot_q;
  logic                        stop_pend_q;
  logic                        busy_q;
  logic                        layer0_q;
  logic [ROW_W-1:0]            data_q;
  logic [COLS-1:0]             latches_q;
  logic [LAYERS-1:0]           layer_sel_q;
  logic [LAYER_AW+COL_AW-1:0]  rd_addr_q;
  logic                        blank_end;
  logic                        latch_end;
  logic                        last_col;
  logic                        pwm_start;
  logic                        pwm_on;
  logic                        pwm_done;

  assign blank_end = (cnt_q == CNT_W'(BLANK_CYC - 32'd1));
  assign latch_end = (cnt_q == CNT_W'(LATCH_CYC - 32'd1));
  assign last_col  = (col_q == COL_TOP);
  assign pwm_start = (state_q == LATCH) && latch_end && last_col;
  assign layer_nxt = (layer_q == '0) ? LAYER_TOP : layer_q - LAYER_AW'(1);

  // rd_addr runs one slot ahead so the word is on rd_data during FETCH and captured as FETCH ends.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      col_q       <= '0;
      layer_q     <= LAYER_TOP;
      oneshot_q   <= 1'b0;
      stop_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      layer0_q    <= 1'b0;
      data_q      <= '0;
      latches_q   <= '0;
      layer_sel_q <= '0;
      rd_addr_q   <= '0;
    end else begin
      if (busy_q && stop) stop_pend_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_q   <= BLANK;
            busy_q    <= 1'b1;
            oneshot_q <= oneshot;
            layer_q   <= LAYER_TOP;
            col_q     <= '0;
            cnt_q     <= '0;
            rd_addr_q <= {LAYER_TOP, COL_AW'(0)};
          end
        end
        BLANK: begin
          if (blank_end) begin
            state_q <= FETCH;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        FETCH: begin
          state_q   <= LATCH;
          data_q    <= rd_data;
          latches_q <= COLS'(1) << col_q;
          cnt_q     <= '0;
          if (!last_col) rd_addr_q <= {layer_q, col_q + COL_AW'(1)};
        end
        LATCH: begin
          if (latch_end) begin
            latches_q <= '0;
            cnt_q     <= '0;
            if (last_col) begin
              state_q     <= DRIVE;
              layer_sel_q <= LAYERS'(1) << layer_q;
              layer0_q    <= (layer_q == '0);
            end else begin
              state_q <= FETCH;
              col_q   <= col_q + COL_AW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DRIVE: begin
          if (pwm_done) begin
            layer_sel_q <= '0;
            layer0_q    <= 1'b0;
            col_q       <= '0;
            cnt_q       <= '0;
            if (stop_pend_q || (oneshot_q && (layer_q == '0))) begin
              state_q     <= IDLE;
              busy_q      <= 1'b0;
              stop_pend_q <= 1'b0;
            end else begin
              state_q   <= BLANK;
              layer_q   <= layer_nxt;
              rd_addr_q <= {layer_nxt, COL_AW'(0)};
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  cube_pwm_timer #(
    .BRIGHT_W (BRIGHT_W),
    .STEP_CYC (STEP_CYC)
  ) u_pwm (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (pwm_start),
    .duty_i  (brightness),
    .on_o    (pwm_on),
    .done_o  (pwm_done)
  );

  assign rd_addr    = rd_addr_q;
  assign data       = data_q;
  assign latches    = latches_q;
  assign layers     = pwm_on ? layer_sel_q : '0;
  assign busy       = busy_q;
  assign frame_done = pwm_done & layer0_q;
  assign layer_idx  = layer_q;

endmodule
